// File: rtl/seq_control_unit.sv
// Multi-cycle FETCH/EXEC/MEM/HALT sequencer: owns pc, fetches over req/ack, decodes datapath controls.
// Optional macro CU_ILLEGAL_TRAP_EN: undefined opcodes pulse illegal and halt instead of acting as NOP.
module seq_control_unit #(
   parameter int OPW     = 32,
   parameter int RSEL_W  = 4,
   parameter int CONST_W = 16,
   parameter int ADDR_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic                imem_ack,
   input  logic [OPW-1:0]      imem_data,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [ADDR_W-1:0]   dmem_addr,
   input  logic                dmem_ack,
   input  logic                zero_in,
   output logic                load_en,
   output logic [RSEL_W-1:0]   a_sel,
   output logic [RSEL_W-1:0]   b_sel,
   output logic [RSEL_W-1:0]   dest_sel,
   output logic [3:0]          op_sel,
   output logic [CONST_W-1:0]  const_in,
   output logic                const_sel,
   output logic                data_sel,
   output logic [ADDR_W-1:0]   pc,
   output logic                halted,
   output logic                illegal
);

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

   localparam logic [4:0] OP_NOP = 5'd0,  OP_MOVA = 5'd1,  OP_ADD = 5'd2,  OP_SUB = 5'd3;
   localparam logic [4:0] OP_AND = 5'd4,  OP_OR   = 5'd5,  OP_XOR = 5'd6,  OP_NOT = 5'd7;
   localparam logic [4:0] OP_ADI = 5'd8,  OP_SBI  = 5'd9,  OP_ANI = 5'd10, OP_ORI = 5'd11;
   localparam logic [4:0] OP_XRI = 5'd12, OP_MOVB = 5'd13, OP_LSR = 5'd14, OP_LSL = 5'd15;
   localparam logic [4:0] OP_LD  = 5'd16, OP_ST   = 5'd17, OP_JMP = 5'd18, OP_BZ  = 5'd19;
   localparam logic [4:0] OP_HLT = 5'd20;

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
   logic [OPW-1:0]      r_ir;
   logic                r_run;
   logic                w_unused_ir;

   logic [4:0]          w_opc;
   logic [RSEL_W-1:0]   w_ra, w_rb, w_rd_r;
   logic [CONST_W-1:0]  w_imm;

   assign w_opc       = r_ir[OPW-1 -: 5];
   assign w_ra        = r_ir[OPW-6 -: RSEL_W];
   assign w_rb        = r_ir[OPW-6-RSEL_W -: RSEL_W];
   assign w_rd_r      = r_ir[OPW-6-2*RSEL_W -: RSEL_W];
   assign w_imm       = r_ir[OPW-6-2*RSEL_W -: CONST_W];
   assign w_unused_ir = ^r_ir;

   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign halted    = (r_state == S_HALT);

   function automatic logic [3:0] f_op_sel(input logic [4:0] opc);
      case (opc)
         OP_SUB, OP_SBI:         f_op_sel = 4'd1;
         OP_AND, OP_ANI:         f_op_sel = 4'd4;
         OP_OR,  OP_ORI, OP_MOVA: f_op_sel = 4'd5;
         OP_XOR, OP_XRI:         f_op_sel = 4'd6;
         OP_NOT:                 f_op_sel = 4'd7;
         OP_LSL:                 f_op_sel = 4'd8;
         OP_LSR:                 f_op_sel = 4'd9;
         OP_MOVB:                f_op_sel = 4'd10;
         default:                f_op_sel = 4'd0;
      endcase
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      dmem_addr   = '0;
      load_en     = 1'b0;
      a_sel       = '0;
      b_sel       = '0;
      dest_sel    = '0;
      op_sel      = '0;
      const_in    = '0;
      const_sel   = 1'b0;
      data_sel    = 1'b0;
      illegal     = 1'b0;
      case (r_state)
         S_FETCH: begin
            // r_run holds off the first request for one cycle after reset release
            imem_req = r_run;
            if (r_run && imem_ack) w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            w_state_nxt = S_FETCH;
            w_pc_nxt    = r_pc + 1'b1;
            case (w_opc)
               OP_NOP: ;
               OP_MOVA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
               OP_MOVB, OP_LSR, OP_LSL: begin
                  load_en   = 1'b1;
                  a_sel     = w_ra;
                  b_sel     = w_rb;
                  dest_sel  = w_rd_r;
                  op_sel    = f_op_sel(w_opc);
                  const_sel = (w_opc == OP_MOVA);
               end
               OP_ADI, OP_SBI, OP_ANI, OP_ORI, OP_XRI: begin
                  load_en   = 1'b1;
                  a_sel     = w_ra;
                  dest_sel  = w_rb;
                  const_in  = w_imm;
                  const_sel = 1'b1;
                  op_sel    = f_op_sel(w_opc);
               end
               OP_LD, OP_ST: begin
                  w_state_nxt = S_MEM;
                  w_pc_nxt    = r_pc;
               end
               OP_JMP: w_pc_nxt = w_imm[ADDR_W-1:0];
               OP_BZ:  if (zero_in) w_pc_nxt = w_imm[ADDR_W-1:0];
               OP_HLT: begin
                  w_state_nxt = S_HALT;
                  w_pc_nxt    = r_pc;
               end
               default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                  illegal     = 1'b1;
                  w_state_nxt = S_HALT;
                  w_pc_nxt    = r_pc;
`endif
               end
            endcase
         end
         S_MEM: begin
            dmem_req  = 1'b1;
            dmem_addr = w_imm[ADDR_W-1:0];
            if (w_opc == OP_LD) begin
               dest_sel = w_rb;
               load_en  = dmem_ack;
               data_sel = dmem_ack;
            end else begin
               dmem_we = 1'b1;
               a_sel   = w_ra;
            end
            if (dmem_ack) begin
               w_state_nxt = S_FETCH;
               w_pc_nxt    = r_pc + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_pc    <= '0;
         r_ir    <= '0;
         r_run   <= 1'b0;
      end else begin
         r_run   <= 1'b1;
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         if (r_state == S_FETCH && r_run && imem_ack) r_ir <= imem_data;
      end
   end

endmodule

// File: doc/seq_control_unit.md
# seq_control_unit

Multi-cycle sequencing control unit for the small register/ALU datapath. It owns the program counter and fetches instructions over a request/acknowledge port, then decodes them into datapath control signals: register selects, ALU/shifter op select, constant and memory-data muxes. It adds load/store, jump, branch-on-zero and halt to the base ALU/immediate instruction set. It sits between instruction memory, data memory and the register-file/ALU datapath.

## Interface
- OPW, 32, instruction width; must satisfy OPW >= 5+3*RSEL_W and OPW >= 5+2*RSEL_W+CONST_W
- RSEL_W, 4, register select width
- CONST_W, 16, immediate width
- ADDR_W, 8, instruction and data address width (ADDR_W <= CONST_W)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_ack  in  1  fetch complete, imem_data valid
- imem_data  in  OPW  instruction word
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  ADDR_W  data address = imm[ADDR_W-1:0]
- dmem_ack  in  1  data access complete
- zero_in  in  1  ALU zero flag of the last executed ALU op
- load_en  out  1  register write strobe
- a_sel, b_sel, dest_sel  out  RSEL_W  register selects
- op_sel  out  4  datapath op code
- const_in  out  CONST_W  immediate
- const_sel  out  1  B operand = const_in
- data_sel  out  1  write data = memory read data
- pc  out  ADDR_W  program counter
- halted  out  1  core stopped
- illegal  out  1  one-cycle pulse on an undefined opcode

## Operation
- Fields: opc = ir[OPW-1 -: 5]. R-format: a, b, dest, consecutive RSEL_W fields below opc. I-format: a, dest, then imm (CONST_W) below opc.
- States: FETCH, EXEC, MEM, HALT. Reset leaves the unit in FETCH with pc=0 and ir=0 (NOP).
- FETCH: imem_req=1, imem_addr=pc. On imem_ack, ir<=imem_data and the state goes to EXEC.
- EXEC: controls are decoded from ir for this one cycle. Next state is MEM for LD/ST, HALT for HLT, otherwise FETCH with pc updated.
- R ops (load_en=1, const_sel=0): ADD op_sel 0, SUB 1, AND 4, OR 5, XOR 6, NOT 7, LSL(15) 8, LSR(14) 9, MOVB(13) 10 (pass B).
- MOVA(1) is R-format with op_sel 5, const_sel=1, const_in=0.
- I ops (load_en=1, const_sel=1, b_sel=0): ADI(8) op_sel 0, SBI(9) 1, ANI(10) 4, ORI(11) 5, XRI(12) 6.
- NOP(0): all controls 0, pc+1.
- LD(16), I-format: in MEM, dmem_req=1, dmem_we=0, dest_sel=dest, data_sel=1. load_en=1 only in the dmem_ack cycle; then pc+1 and FETCH.
- ST(17), I-format: in MEM, dmem_req=1, dmem_we=1, a_sel=a (store source). Completes on dmem_ack; then pc+1 and FETCH. load_en=0.
- JMP(18): pc<=imm[ADDR_W-1:0].
- BZ(19): pc<=imm if zero_in=1 in the EXEC cycle, else pc+1.
- HLT(20): enters HALT; halted=1; no further requests. Only rst leaves HALT.
- Opcodes 21..31 are undefined; handling is set by Configuration.
- pc arithmetic is modulo 2^ADDR_W: pc+1 wraps from all-ones to 0.
- Outside EXEC and MEM, every control output is 0.

## Timing
- Minimum CPI is 2 (imem_ack in the first FETCH cycle). LD/ST take at least 3 cycles.
- imem_req and imem_addr hold stable until imem_ack. dmem_req, dmem_we and dmem_addr hold stable until dmem_ack.
- An ack sampled while no request is asserted is ignored.
- Controls are combinational from the registered state and ir only; they are never combinational from acks, except load_en and data_sel gating in MEM for LD.
- pc updates on the edge that leaves EXEC (non-memory ops) or on the edge that leaves MEM.
- rst asserted at any time, including mid-handshake, asynchronously clears state, pc, ir, halted and illegal. All outputs go to 0 within the same cycle; imem_req rises one cycle after rst deasserts.

## Configuration
- CU_ILLEGAL_TRAP_EN defined: an undefined opcode pulses illegal=1 in its EXEC cycle and then goes to HALT (halted=1, pc unchanged).
- CU_ILLEGAL_TRAP_EN undefined: an undefined opcode executes as NOP (pc+1) and illegal is tied to 0.

## Test plan
- Reset with imem_ack tied to 1, program ADD r1,r2,r3 (R-format) -> EXEC cycle shows a_sel=2, b_sel=3, dest_sel=1, op_sel=0, load_en=1; pc=1 afterwards; CPI=2.
- ADI r4 <- r5 + 0x0007 -> const_sel=1, const_in=7, op_sel=0, b_sel=0, dest_sel=4; with imem_ack delayed 3 cycles, imem_addr stays stable and CPI=5.
- LD r6, [0x20] with dmem_ack after 2 cycles -> dmem_addr=0x20, dmem_we=0, load_en=1 and data_sel=1 only in the ack cycle; load_en=0 in earlier MEM cycles.
- BZ 0x40 with zero_in=1 -> pc=0x40. Same with zero_in=0 -> pc+1. Also: pc=0xFF followed by NOP -> pc wraps to 0x00.
- Opcode 25 -> with CU_ILLEGAL_TRAP_EN: illegal pulses for 1 cycle, halted=1, imem_req stays 0. Without it: pc+1, illegal=0.
- rst asserted during an outstanding dmem_req -> dmem_req=0 and pc=0 immediately; after release, fetch restarts at address 0. HLT -> halted=1 until rst.
